// File: rtl/netbus_pkg.sv
// -----------------------------------------------------------------------------
// netbus_pkg
// Shared NetBus definitions used by the packetizer, the field combiner and any
// future splitter.
//   NB_CMD_W / NB_ID_W   : command and id field widths of a NetBus beat
//   NB_LEN_W             : request length field width (0 encodes 256 bytes)
//   NB_CNT_W             : decoded length / beat counter width (holds 256)
//   nb_packed_width()    : width of one flat NetBus word for a payload width
//   nb_state_e           : packetizer sequencing states
// -----------------------------------------------------------------------------
package netbus_pkg;

   localparam int NB_CMD_W = 2;
   localparam int NB_ID_W  = 5;
   localparam int NB_LEN_W = 8;
   localparam int NB_CNT_W = 9;

   // DATAX (8*DW) + STRB (DW) + CMD + DID + SID + FIRST + LAST
   function automatic int nb_packed_width(input int data_width);
      return data_width * 9 + 14;
   endfunction

   typedef enum logic {
      NB_IDLE  = 1'b0,
      NB_BURST = 1'b1
   } nb_state_e;

endpackage

// File: rtl/netbus_strb_gen.sv
// -----------------------------------------------------------------------------
// netbus_strb_gen
// Combinational last-beat byte-enable generator. Given a decoded packet length
// (1..256 bytes) it produces the strobe of the final beat: all ones when the
// length is a whole number of beats, otherwise the low (len mod DATA_WIDTH)
// bits set.
//   len       in  NB_CNT_W    decoded packet length in bytes
//   last_strb out DATA_WIDTH  byte enables for the final beat
// -----------------------------------------------------------------------------
module netbus_strb_gen
   import netbus_pkg::*;
#(
   parameter int DATA_WIDTH = 4
) (
   input  logic [NB_CNT_W-1:0]   len,
   output logic [DATA_WIDTH-1:0] last_strb
);

   // DATA_WIDTH is a power of two, so the modulo is a mask.
   localparam logic [NB_CNT_W-1:0] REM_MASK = NB_CNT_W'(DATA_WIDTH - 1);

   logic [NB_CNT_W-1:0] rem;

   assign rem = len & REM_MASK;

   genvar gi;
   generate
      for (gi = 0; gi < DATA_WIDTH; gi++) begin : g_strb
         assign last_strb[gi] = (rem == '0) || (NB_CNT_W'(gi) < rem);
      end
   endgenerate

endmodule

// File: rtl/netbus_packetizer.sv
// -----------------------------------------------------------------------------
// netbus_packetizer
// Slices a payload word stream into NetBus beats for one packet request at a
// time and presents each beat's field set through a single output register.
//   clk, rst_n            clock, asynchronous active-low reset
//   req_valid/req_ready   packet request handshake
//   req_cmd/did/sid/len   request fields (len 0 means 256 bytes)
//   in_valid/in_ready     payload word handshake, in_data byte 0 = [7:0]
//   out_valid/out_ready   beat handshake
//   datax, strb           beat payload and byte enables
//   cmd, did, sid         request fields copied onto every beat
//   first, last           packet boundary markers
// -----------------------------------------------------------------------------
module netbus_packetizer
   import netbus_pkg::*;
#(
   parameter int DATA_WIDTH = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic [NB_CMD_W-1:0]     req_cmd,
   input  logic [NB_ID_W-1:0]      req_did,
   input  logic [NB_ID_W-1:0]      req_sid,
   input  logic [NB_LEN_W-1:0]     req_len,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [DATA_WIDTH*8-1:0] in_data,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [DATA_WIDTH*8-1:0] datax,
   output logic [DATA_WIDTH-1:0]   strb,
   output logic [NB_CMD_W-1:0]     cmd,
   output logic [NB_ID_W-1:0]      did,
   output logic [NB_ID_W-1:0]      sid,
   output logic                    first,
   output logic                    last
);

   localparam int BEAT_SHIFT = $clog2(DATA_WIDTH);

   nb_state_e               state_reg, state_next;
   logic [NB_CNT_W-1:0]     index_reg;
   logic [NB_CNT_W-1:0]     beats_reg;
   logic [DATA_WIDTH-1:0]   last_strb_reg;
   logic [NB_CMD_W-1:0]     cmd_lat_reg;
   logic [NB_ID_W-1:0]      did_lat_reg;
   logic [NB_ID_W-1:0]      sid_lat_reg;

   logic [NB_CNT_W-1:0]     len_full;
   logic [NB_CNT_W:0]       len_round;
   logic [NB_CNT_W-1:0]     beats_next;
   logic [DATA_WIDTH-1:0]   last_strb_next;
   logic                    req_accept;
   logic                    load;
   logic                    is_last;

   // Request decode: length 0 stands for 256, beats = ceil(len / DATA_WIDTH).
   assign len_full   = (req_len == '0) ? NB_CNT_W'(256) : {1'b0, req_len};
   assign len_round  = {1'b0, len_full} + (NB_CNT_W + 1)'(DATA_WIDTH - 1);
   assign beats_next = NB_CNT_W'(len_round >> BEAT_SHIFT);

   netbus_strb_gen #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_strb_gen (
      .len       (len_full),
      .last_strb (last_strb_next)
   );

   assign req_accept = req_ready && req_valid;
   assign is_last    = (index_reg == beats_reg - NB_CNT_W'(1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= NB_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      req_ready  = 1'b0;
      in_ready   = 1'b0;
      load       = 1'b0;
      case (state_reg)
         NB_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               state_next = NB_BURST;
            end
         end
         NB_BURST: begin
            // A new word may enter only if the output register is empty or
            // being drained this cycle; there is no skid storage.
            in_ready = !out_valid || out_ready;
            load     = in_valid && (!out_valid || out_ready);
            if (load && is_last) begin
               state_next = NB_IDLE;
            end
         end
         default: state_next = NB_IDLE;
      endcase
   end

   // Per-packet context, captured once at request accept.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         index_reg     <= '0;
         beats_reg     <= '0;
         last_strb_reg <= '0;
         cmd_lat_reg   <= '0;
         did_lat_reg   <= '0;
         sid_lat_reg   <= '0;
      end else if (req_accept) begin
         index_reg     <= '0;
         beats_reg     <= beats_next;
         last_strb_reg <= last_strb_next;
         cmd_lat_reg   <= req_cmd;
         did_lat_reg   <= req_did;
         sid_lat_reg   <= req_sid;
      end else if (load) begin
         index_reg     <= index_reg + NB_CNT_W'(1);
      end
   end

   // Beat output register. The field copies live here rather than in the
   // request latch so a held last beat survives the next request accept.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         datax     <= '0;
         strb      <= '0;
         cmd       <= '0;
         did       <= '0;
         sid       <= '0;
         first     <= 1'b0;
         last      <= 1'b0;
      end else if (load) begin
         out_valid <= 1'b1;
         datax     <= in_data;
         strb      <= is_last ? last_strb_reg : '1;
         cmd       <= cmd_lat_reg;
         did       <= did_lat_reg;
         sid       <= sid_lat_reg;
         first     <= (index_reg == '0);
         last      <= is_last;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_netbus_packetizer.sv
// -----------------------------------------------------------------------------
// tb_netbus_packetizer
// Self-checking bench for netbus_packetizer at DATA_WIDTH=4. Expected beats are
// derived from the packet length with plain arithmetic; occupancy of the output
// register is tracked as (words accepted - beats drained).
// -----------------------------------------------------------------------------
module tb_netbus_packetizer;

   localparam int DW = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic [1:0]    req_cmd = '0;
   logic [4:0]    req_did = '0;
   logic [4:0]    req_sid = '0;
   logic [7:0]    req_len = '0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [31:0]   in_data = '0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [31:0]   datax;
   logic [3:0]    strb;
   logic [1:0]    cmd;
   logic [4:0]    did;
   logic [4:0]    sid;
   logic          first;
   logic          last;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   netbus_packetizer #(.DATA_WIDTH(DW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_cmd   (req_cmd),
      .req_did   (req_did),
      .req_sid   (req_sid),
      .req_len   (req_len),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .datax     (datax),
      .strb      (strb),
      .cmd       (cmd),
      .did       (did),
      .sid       (sid),
      .first     (first),
      .last      (last)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Bytes remaining in beat k, capped at the beat width, as a low-bit mask.
   function automatic logic [3:0] exp_strb(input int len_bytes, input int k);
      int b;
      b = len_bytes - DW * k;
      if (b > DW) b = DW;
      return 4'((1 << b) - 1);
   endfunction

   // mode 0: always ready/valid; 1: random ready/valid; 2: out_ready low 3 cycles
   task automatic send_packet(input int len_code, input logic [1:0] c,
                              input logic [4:0] d, input logic [4:0] s,
                              input int mode, input bit skip_req, input bit pend,
                              input int p_len, input logic [1:0] pc,
                              input logic [4:0] pd, input logic [4:0] ps);
      int          len_bytes, nb, sent, rx, cyc, w;
      bit          pend_acc, exp_ov, exp_ir, exp_rr;
      logic [31:0] words [0:255];
      len_bytes = (len_code == 0) ? 256 : len_code;
      nb        = (len_bytes + DW - 1) / DW;
      for (int k = 0; k < nb; k++) words[k] = $urandom;

      if (!skip_req) begin
         @(negedge clk);
         req_valid = 1'b1; req_cmd = c; req_did = d; req_sid = s;
         req_len = 8'(len_code); in_valid = 1'b0; out_ready = 1'b1;
         w = 0;
         #1;
         while (req_ready !== 1'b1 && w < 50) begin
            @(negedge clk); #1; w++;
         end
         chk("req_accept", req_ready, 1);
         @(posedge clk);
      end

      sent = 0; rx = 0; cyc = 0; pend_acc = 1'b0;
      while (rx < nb && cyc < 3000) begin
         @(negedge clk);
         req_valid = pend && !pend_acc;
         if (pend) begin
            req_cmd = pc; req_did = pd; req_sid = ps; req_len = 8'(p_len);
         end else begin
            req_cmd = 2'($urandom); req_did = 5'($urandom);
            req_sid = 5'($urandom); req_len = 8'($urandom);
         end
         case (mode)
            1:       out_ready = ($urandom_range(0, 3) != 0);
            2:       out_ready = !(cyc >= 3 && cyc <= 5);
            default: out_ready = 1'b1;
         endcase
         if (sent < nb) begin
            in_valid = (mode == 1) ? ($urandom_range(0, 2) != 0) : 1'b1;
            in_data  = words[sent];
         end else begin
            // words beyond the packet are offered but must not be taken
            in_valid = !pend;
            in_data  = $urandom;
         end
         #1;
         exp_ov = (sent > rx);
         exp_rr = (sent == nb);
         exp_ir = (sent < nb) && (!exp_ov || out_ready);
         chk("out_valid", out_valid, exp_ov);
         if (exp_ov) begin
            chk("datax", datax, words[rx]);
            chk("strb",  strb,  exp_strb(len_bytes, rx));
            chk("first", first, rx == 0);
            chk("last",  last,  rx == nb - 1);
            chk("cmd",   cmd,   c);
            chk("did",   did,   d);
            chk("sid",   sid,   s);
         end
         if (!pend_acc) begin
            chk("req_ready", req_ready, exp_rr);
            chk("in_ready",  in_ready,  exp_ir);
            if (in_valid && exp_ir) sent++;
            if (pend && exp_rr) pend_acc = 1'b1;
         end
         if (exp_ov && out_ready) rx++;
         @(posedge clk);
         cyc++;
      end
      chk("beats_drained", rx, nb);
      chk("words_consumed", sent, nb);
      if (pend) chk("pend_accept", pend_acc, 1);
      @(negedge clk);
      req_valid = 1'b0; in_valid = 1'b0;
      $display("packet len=%0d beats=%0d mode=%0d cycles=%0d", len_bytes, nb, mode, cyc);
   endtask

   initial begin
      #1 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_req_ready", req_ready, 1);
      chk("rst_in_ready",  in_ready,  0);
      chk("rst_datax",     datax,     0);
      chk("rst_fields",    {strb, cmd, did, sid, first, last}, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Directed lengths
      send_packet(8,  2'd1, 5'h03, 5'h11, 0, 0, 0, 0, '0, '0, '0);
      send_packet(5,  2'd2, 5'h1F, 5'h00, 0, 0, 0, 0, '0, '0, '0);
      send_packet(1,  2'd3, 5'h0A, 5'h15, 0, 0, 0, 0, '0, '0, '0);
      send_packet(0,  2'd0, 5'h07, 5'h1C, 0, 0, 0, 0, '0, '0, '0);
      // Backpressure hold mid-burst
      send_packet(16, 2'd1, 5'h12, 5'h09, 2, 0, 0, 0, '0, '0, '0);
      // Request held during a burst, then taken with its own fields
      send_packet(12, 2'd2, 5'h04, 5'h05, 0, 0, 1, 6, 2'd3, 5'h19, 5'h0E);
      send_packet(6,  2'd3, 5'h19, 5'h0E, 0, 1, 0, 0, '0, '0, '0);

      // Reset during beat 2 of a 4-beat packet
      @(negedge clk);
      req_valid = 1'b1; req_cmd = 2'd3; req_did = 5'h1A; req_sid = 5'h05; req_len = 8'd16;
      #1 chk("rstpkt_req_ready", req_ready, 1);
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         if (k > 0) @(negedge clk);
         in_valid = 1'b1; out_ready = 1'b1; in_data = $urandom;
      end
      @(posedge clk);
      @(negedge clk);
      #1;
      chk("rstpkt_beat2_valid", out_valid, 1);
      chk("rstpkt_beat2_first", first, 0);
      rst_n = 1'b0; in_valid = 1'b0;
      #1;
      chk("midrst_out_valid", out_valid, 0);
      chk("midrst_datax",     datax, 0);
      chk("midrst_fields",    {strb, cmd, did, sid, first, last}, 0);
      chk("midrst_req_ready", req_ready, 1);
      chk("midrst_in_ready",  in_ready, 0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("postrst_req_ready", req_ready, 1);
      chk("postrst_out_valid", out_valid, 0);
      send_packet(4, 2'd1, 5'h02, 5'h03, 0, 0, 0, 0, '0, '0, '0);

      // Randomized packets with random flow control
      for (int p = 0; p < 12; p++) begin
         send_packet(int'($urandom_range(0, 255)), 2'($urandom), 5'($urandom),
                     5'($urandom), (p % 3 == 0) ? 0 : 1, 0, 0, 0, '0, '0, '0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
